// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
//   Shared definitions for the FPU request dispatcher and its clients.
//   - Operation_t    : 4-bit FPU operation code
//   - disp_state_t   : dispatcher sequencing states
//   - IEEE-754 single-precision field positions and handy constants
//   - fp_is_nan      : helper to classify a single-precision bit pattern
// -----------------------------------------------------------------------------
package fpu_pkg;

  typedef enum logic [3:0] {
    ADD = 4'b0000,
    SUB = 4'b0001,
    MUL = 4'b0010,
    DIV = 4'b0011
  } Operation_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } disp_state_t;

  // IEEE-754 single precision layout
  localparam int FP_W        = 32;
  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_MSB  = 30;
  localparam int FP_EXP_LSB  = 23;
  localparam int FP_EXP_W    = 8;
  localparam int FP_MAN_W    = 23;
  localparam int FP_EXP_BIAS = 127;

  localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_POS_ONE  = 32'h3F80_0000;
  localparam logic [FP_W-1:0] FP_QNAN     = 32'h7FC0_0000;

  // NaN: exponent all ones with a non-zero mantissa
  function automatic logic fp_is_nan(input logic [FP_W-1:0] v);
    return (&v[FP_EXP_MSB:FP_EXP_LSB]) && (|v[FP_MAN_W-1:0]);
  endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// -----------------------------------------------------------------------------
// fpu_req_fifo
//   In-order request queue of DEPTH entries (DEPTH a power of two >= 2).
//   Pointers wrap naturally because the pointer width is exactly log2(DEPTH).
//   Full/empty are derived from the registered occupancy only, so a pop in the
//   same cycle never lets a push into a full queue.
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_push, i_wdata     write request and entry (ignored while full)
//   i_pop               read request (ignored while empty)
//   o_rdata             current head entry
//   o_count             registered occupancy 0..DEPTH
//   o_full, o_empty     occupancy flags
// -----------------------------------------------------------------------------
module fpu_req_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 72,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage carries no reset; only valid entries (tracked by count) are read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_dispatch.sv
// -----------------------------------------------------------------------------
// fpu_dispatch
//   Queues FPU requests and feeds them one at a time to an FPU over an
//   operand handshake, collects the result over a result handshake and
//   presents it (with the request tag and op) on a response handshake.
//   Only one operation is in flight; each op runs IDLE -> ISSUE -> WAIT ->
//   RESPOND -> IDLE.
// Ports
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_req_valid / o_req_ready      request handshake
//   i_req_op/_a/_b/_tag            request payload
//   o_operation, o_data_a/_b       operands to the FPU (valid while o_input_rdy)
//   o_input_rdy / i_input_ack      operand handshake
//   i_output_rdy / o_output_ack    result handshake, i_result is the FPU result
//   o_rsp_valid / i_rsp_ready      response handshake
//   o_rsp_result/_tag/_op          response payload
//   o_count, o_busy                queue occupancy, activity flag
// -----------------------------------------------------------------------------
module fpu_dispatch
  import fpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int TAG_W = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  Operation_t       i_req_op,
  input  logic [FP_W-1:0]  i_req_a,
  input  logic [FP_W-1:0]  i_req_b,
  input  logic [TAG_W-1:0] i_req_tag,
  output Operation_t       o_operation,
  output logic [FP_W-1:0]  o_data_a,
  output logic [FP_W-1:0]  o_data_b,
  output logic             o_input_rdy,
  input  logic             i_input_ack,
  input  logic             i_output_rdy,
  output logic             o_output_ack,
  input  logic [FP_W-1:0]  i_result,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [FP_W-1:0]  o_rsp_result,
  output logic [TAG_W-1:0] o_rsp_tag,
  output Operation_t       o_rsp_op,
  output logic [CNT_W-1:0] o_count,
  output logic             o_busy
);

  typedef struct packed {
    Operation_t       op;
    logic [FP_W-1:0]  a;
    logic [FP_W-1:0]  b;
    logic [TAG_W-1:0] tag;
  } req_entry_t;

  localparam int ENTRY_W = $bits(req_entry_t);

  disp_state_t      r_state;
  disp_state_t      w_next;

  req_entry_t       w_wr_entry;
  logic [ENTRY_W-1:0] w_head_bits;
  req_entry_t       w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_capture;

  logic [FP_W-1:0]  r_rsp_result;
  logic [TAG_W-1:0] r_rsp_tag;
  Operation_t       r_rsp_op;
  logic             r_output_ack;

  // ---------------------------------------------------------------------------
  // Request queue
  // ---------------------------------------------------------------------------
  assign w_wr_entry = '{op: i_req_op, a: i_req_a, b: i_req_b, tag: i_req_tag};
  assign w_head     = req_entry_t'(w_head_bits);

  // Ready comes from the registered count only: no bypass of a full queue.
  assign o_req_ready = !w_full;
  assign w_push      = i_req_valid && o_req_ready;
  // input_ack is only meaningful while issuing.
  assign w_pop       = (r_state == ST_ISSUE) && i_input_ack;
  // output_rdy is only meaningful while waiting for the FPU.
  assign w_capture   = (r_state == ST_WAIT) && i_output_rdy;

  fpu_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_req_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_wdata (w_wr_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head_bits),
    .o_count (o_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // ---------------------------------------------------------------------------
  // Sequencer: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (!w_empty)     w_next = ST_ISSUE;
      ST_ISSUE:   if (i_input_ack)  w_next = ST_WAIT;
      ST_WAIT:    if (i_output_rdy) w_next = ST_RESPOND;
      ST_RESPOND: if (i_rsp_ready)  w_next = ST_IDLE;
      default:                      w_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer: outputs
  // ---------------------------------------------------------------------------
  // Operands are forced to zero outside ISSUE so the FPU never sees stale or
  // unreset queue storage. While issuing, later pushes land behind the head,
  // so the driven operands stay stable.
  always_comb begin
    o_input_rdy = 1'b0;
    o_rsp_valid = 1'b0;
    o_operation = ADD;
    o_data_a    = '0;
    o_data_b    = '0;
    case (r_state)
      ST_ISSUE: begin
        o_input_rdy = 1'b1;
        o_operation = w_head.op;
        o_data_a    = w_head.a;
        o_data_b    = w_head.b;
      end
      ST_RESPOND: begin
        o_rsp_valid = 1'b1;
      end
      default: begin
        o_input_rdy = 1'b0;
      end
    endcase
  end

  assign o_busy = (r_state != ST_IDLE) || !w_empty;

  // ---------------------------------------------------------------------------
  // Response register and result acknowledge
  // ---------------------------------------------------------------------------
  // Tag/op are latched when the head leaves the queue; the result is latched
  // when the FPU presents it. output_ack is a registered one-cycle pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_result <= '0;
      r_rsp_tag    <= '0;
      r_rsp_op     <= ADD;
      r_output_ack <= 1'b0;
    end else begin
      r_output_ack <= w_capture;
      if (w_pop) begin
        r_rsp_tag <= w_head.tag;
        r_rsp_op  <= w_head.op;
      end
      if (w_capture) begin
        r_rsp_result <= i_result;
      end
    end
  end

  assign o_rsp_result = r_rsp_result;
  assign o_rsp_tag    = r_rsp_tag;
  assign o_rsp_op     = r_rsp_op;
  assign o_output_ack = r_output_ack;

endmodule

// File: tb/tb_fpu_dispatch.sv
module tb_fpu_dispatch;
  import fpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  Operation_t       req_op = ADD;
  logic [31:0]      req_a = '0, req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  Operation_t       operation;
  logic [31:0]      data_a, data_b;
  logic             input_rdy;
  logic             input_ack = 1'b0;
  logic             output_rdy = 1'b0;
  logic             output_ack;
  logic [31:0]      result = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  Operation_t       rsp_op;
  logic [CNT_W-1:0] count;
  logic             busy;

  always #5 clk = ~clk;

  fpu_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op(req_op), .i_req_a(req_a), .i_req_b(req_b), .i_req_tag(req_tag),
    .o_operation(operation), .o_data_a(data_a), .o_data_b(data_b),
    .o_input_rdy(input_rdy), .i_input_ack(input_ack),
    .i_output_rdy(output_rdy), .o_output_ack(output_ack), .i_result(result),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_tag(rsp_tag), .o_rsp_op(rsp_op),
    .o_count(count), .o_busy(busy)
  );

  typedef struct {
    logic [3:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic [3:0]       op;
  } rsp_t;

  req_t stim_q[$];   // requests still to be offered
  req_t fifo_q[$];   // requests accepted but not yet taken by the FPU
  req_t cur;         // request in flight / being responded
  rsp_t rsp_log[$];  // every response accepted, in order

  int checks = 0;
  int failures = 0;
  int stage = 0;     // 0: nothing in flight, 1: FPU working, 2: response offered
  int starve = 0;
  bit ack_exp = 1'b0;
  bit rand_stim = 1'b0;
  logic [31:0] fpu_res_q = '0;
  int p_valid = 100, p_iack = 100, p_ordy = 100, p_rrdy = 100;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stand-in FPU: known IEEE vectors, otherwise an arbitrary integer mix.
  function automatic logic [31:0] fpu_ref(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    if (op == 4'd0 && a == 32'h3F800000 && b == 32'h3C23D70A) return 32'h3F8147AE;
    if (op == 4'd2 && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    if (op == 4'd3 && a == 32'h40800000 && b == 32'h40000000) return 32'h40000000;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a * b;
      default: r = a ^ {b[15:0], b[31:16]};
    endcase
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.op  = 4'($urandom_range(3));
    r.a   = $urandom();
    r.b   = $urandom();
    r.tag = TAG_W'($urandom());
    return r;
  endfunction

  function automatic req_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [TAG_W-1:0] tag);
    req_t r;
    r.op = op; r.a = a; r.b = b; r.tag = tag;
    return r;
  endfunction

  // One clock: check outputs against the model, drive next inputs, advance model.
  task automatic step();
    int  old_stage;
    bit  push, iss, cap, rsp;
    @(negedge clk);
    chk("count", count, fifo_q.size());
    chk("req_ready", req_ready, fifo_q.size() < DEPTH);
    chk("busy", busy, (stage != 0) || (fifo_q.size() != 0));
    chk("rsp_valid", rsp_valid, stage == 2);
    chk("output_ack", output_ack, ack_exp);
    if (stage == 2) begin
      chk("rsp_result", rsp_result, fpu_ref(cur.op, cur.a, cur.b));
      chk("rsp_tag", rsp_tag, cur.tag);
      chk("rsp_op", rsp_op, cur.op);
    end
    if (stage != 0 || fifo_q.size() == 0) begin
      chk("input_rdy_off", input_rdy, 1'b0);
      starve = 0;
    end else if (input_rdy) begin
      chk("issue_op", operation, fifo_q[0].op);
      chk("issue_a", data_a, fifo_q[0].a);
      chk("issue_b", data_b, fifo_q[0].b);
      starve = 0;
    end else begin
      starve++;
      if (starve == 2) chk("issue_latency", input_rdy, 1'b1);
    end

    if (rand_stim && stim_q.size() == 0) stim_q.push_back(rand_req());
    req_valid = (stim_q.size() != 0) && ($urandom_range(99) < p_valid);
    if (stim_q.size() != 0) begin
      req_op  = Operation_t'(stim_q[0].op);
      req_a   = stim_q[0].a;
      req_b   = stim_q[0].b;
      req_tag = stim_q[0].tag;
    end else begin
      req_a = $urandom();
      req_b = $urandom();
    end
    input_ack  = $urandom_range(99) < p_iack;
    output_rdy = $urandom_range(99) < p_ordy;
    result     = (stage == 1) ? fpu_res_q : $urandom();
    rsp_ready  = $urandom_range(99) < p_rrdy;

    old_stage = stage;
    push = req_valid && req_ready;
    iss  = input_rdy && input_ack && old_stage == 0 && fifo_q.size() != 0;
    cap  = (old_stage == 1) && output_rdy;
    rsp  = (old_stage == 2) && rsp_ready;
    ack_exp = cap;
    if (rsp) begin
      rsp_log.push_back('{rsp_result, rsp_tag, rsp_op});
      stage = 0;
    end
    if (cap) stage = 2;
    if (iss) begin
      cur = fifo_q.pop_front();
      fpu_res_q = fpu_ref(operation, data_a, data_b);
      stage = 1;
    end
    if (push) fifo_q.push_back(stim_q.pop_front());
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (stim_q.size() == 0 && fifo_q.size() == 0 && stage == 0) break;
      step();
    end
    chk("drain_done", stim_q.size() + fifo_q.size() + stage, 0);
  endtask

  task automatic reset_values(input string pfx);
    chk({pfx, "_count"}, count, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_req_ready"}, req_ready, 1);
    chk({pfx, "_input_rdy"}, input_rdy, 0);
    chk({pfx, "_output_ack"}, output_ack, 0);
    chk({pfx, "_rsp_valid"}, rsp_valid, 0);
    chk({pfx, "_rsp_result"}, rsp_result, 0);
    chk({pfx, "_rsp_tag"}, rsp_tag, 0);
    chk({pfx, "_rsp_op"}, rsp_op, 0);
    chk({pfx, "_operation"}, operation, 0);
    chk({pfx, "_data_a"}, data_a, 0);
    chk({pfx, "_data_b"}, data_b, 0);
  endtask

  initial begin
    int base;
    int n;
    repeat (3) @(negedge clk);
    reset_values("rst");
    rst_n = 1'b1;

    // Single ADD, with output_rdy high all the time (spurious outside WAIT)
    base = rsp_log.size();
    stim_q.push_back(mk(4'd0, 32'h3F800000, 32'h3C23D70A, 4'd3));
    drain(100);
    chk("single_n", rsp_log.size(), base + 1);
    if (rsp_log.size() > base) begin
      chk("single_res", rsp_log[base].res, 32'h3F8147AE);
      chk("single_tag", rsp_log[base].tag, 3);
      chk("single_op", rsp_log[base].op, 0);
    end

    // Ordering
    base = rsp_log.size();
    stim_q.push_back(mk(4'd2, 32'h40000000, 32'h40000000, 4'd1));
    stim_q.push_back(mk(4'd3, 32'h40800000, 32'h40000000, 4'd2));
    drain(100);
    chk("order_n", rsp_log.size(), base + 2);
    if (rsp_log.size() > base + 1) begin
      chk("order0_res", rsp_log[base].res, 32'h40800000);
      chk("order0_tag", rsp_log[base].tag, 1);
      chk("order1_res", rsp_log[base + 1].res, 32'h40000000);
      chk("order1_tag", rsp_log[base + 1].tag, 2);
    end

    // Fill with the FPU stalled in ISSUE while output_rdy is spuriously high
    p_iack = 0; p_ordy = 100; p_rrdy = 0;
    for (int i = 0; i < 5; i++) stim_q.push_back(rand_req());
    repeat (12) step();
    chk("fill_count", count, 4);
    chk("fill_ready", req_ready, 0);
    chk("fill_ack", output_ack, 0);
    p_iack = 100; p_rrdy = 100;
    drain(200);

    // Response backpressure with a second request waiting
    p_rrdy = 0;
    stim_q.push_back(rand_req());
    stim_q.push_back(rand_req());
    repeat (16) step();
    chk("bp_valid", rsp_valid, 1);
    chk("bp_input_rdy", input_rdy, 0);
    p_rrdy = 100;
    drain(100);

    // Reset while WAITing with two entries queued
    p_ordy = 0; p_iack = 100;
    for (int i = 0; i < 3; i++) stim_q.push_back(rand_req());
    for (int i = 0; i < 50; i++) begin
      if (stage == 1 && fifo_q.size() == 2 && stim_q.size() == 0) break;
      step();
    end
    chk("pre_rst_queued", count, 2);
    base = rsp_log.size();
    #2 rst_n = 1'b0;
    #1 reset_values("midrst");
    req_valid = 1'b0; input_ack = 1'b0; output_rdy = 1'b0; rsp_ready = 1'b0;
    fifo_q.delete(); stage = 0; ack_exp = 1'b0; starve = 0;
    @(negedge clk);
    reset_values("midrst_hold");
    rst_n = 1'b1;
    p_ordy = 100;
    repeat (4) step();
    chk("no_rsp_after_rst", rsp_log.size(), base);
    stim_q.push_back(mk(4'd1, 32'h12345678, 32'h00000078, 4'd9));
    drain(100);
    chk("post_rst_n", rsp_log.size(), base + 1);
    if (rsp_log.size() > base) chk("post_rst_res", rsp_log[base].res, 32'h12345600);

    // Randomized traffic
    base = rsp_log.size();
    rand_stim = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (i % 250 == 0) begin
        p_valid = $urandom_range(100, 10);
        p_iack  = $urandom_range(100, 10);
        p_ordy  = $urandom_range(100, 10);
        p_rrdy  = $urandom_range(100, 10);
      end
      step();
    end
    rand_stim = 1'b0;
    p_valid = 100; p_iack = 100; p_ordy = 100; p_rrdy = 100;
    drain(500);
    n = rsp_log.size() - base;
    chk("rand_progress", n > 50, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
